// File: rtl/core_switch_ctrl_if.sv
// Bundle of the core-select control signals shared between the switch controller
// and the core/mux logic that consumes its outputs.
interface core_switch_ctrl_if;
    logic       chip_sel_i;
    logic       bus_req_i;
    logic       sel_o;
    logic       core0_rst_n_o;
    logic       core1_rst_n_o;
    logic       switching_o;
    logic       timeout_o;
    logic [7:0] switch_cnt_o;

    // Side that drives the raw select and the bus request, and observes the controller.
    modport master (
        output chip_sel_i,
        output bus_req_i,
        input  sel_o,
        input  core0_rst_n_o,
        input  core1_rst_n_o,
        input  switching_o,
        input  timeout_o,
        input  switch_cnt_o
    );

    // The switch controller itself.
    modport slave (
        input  chip_sel_i,
        input  bus_req_i,
        output sel_o,
        output core0_rst_n_o,
        output core1_rst_n_o,
        output switching_o,
        output timeout_o,
        output switch_cnt_o
    );
endinterface

// File: rtl/core_switch_ctrl.sv
// Safe hand-over of the shared rib master ports between the two cores: synchronise and
// debounce chip_sel, drain the active core's bus request, hold both cores in reset, then
// release only the newly selected core.
module core_switch_ctrl #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned DRAIN_TIMEOUT = 255,
    parameter int unsigned RST_HOLD      = 8,
    parameter int unsigned CNT_W         = 8
) (
    input logic               clk,
    input logic               rst,
    core_switch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StRun, StDebounce, StDrain, StHold} state_e;

    localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DrainLast  = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(RST_HOLD - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             core0_q, core0_d;
    logic             core1_q, core1_d;
    logic             switching_q, switching_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       switch_cnt_q, switch_cnt_d;
    // Select value at HOLD entry, and whether the current HOLD came from rst (never counted).
    logic             hold_sel_q, hold_sel_d;
    logic             from_rst_q, from_rst_d;
    logic             run_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // chip_sel synchroniser; shift in the raw asynchronous switch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.chip_sel_i};
        end
    end

    // Next-state and registered-output decode; outputs follow the next state so they
    // are always consistent with the state register.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        timeout_d    = timeout_q;
        switch_cnt_d = switch_cnt_q;
        hold_sel_d   = hold_sel_q;
        from_rst_d   = from_rst_q;

        unique case (state_q)
            StRun: begin
                if (sync != sel_q) begin
                    state_d = StDebounce;
                    cnt_d   = '0;
                end
            end
            StDebounce: begin
                if (sync == sel_q) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (!bus.bus_req_i || cnt_q == DrainLast) begin
                    // An idle bus in the terminal cycle is a normal exit, not a timeout.
                    timeout_d  = timeout_q | bus.bus_req_i;
                    state_d    = StHold;
                    cnt_d      = '0;
                    hold_sel_d = sel_q;
                    from_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                // Both cores are in reset, so the mux select may follow sync freely.
                sel_d = sync;
                if (cnt_q == HoldLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    if (!from_rst_q && sync != hold_sel_q) begin
                        switch_cnt_d = switch_cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StHold;
                cnt_d   = '0;
            end
        endcase

        run_d       = (state_d != StHold);
        core0_d     = run_d & ~sel_d;
        core1_d     = run_d & sel_d;
        switching_d = (state_d == StDrain) || (state_d == StHold);
    end

    // State and output registers; rst aborts any switch and re-enters HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StHold;
            cnt_q        <= '0;
            sel_q        <= 1'b0;
            core0_q      <= 1'b0;
            core1_q      <= 1'b0;
            switching_q  <= 1'b1;
            timeout_q    <= 1'b0;
            switch_cnt_q <= 8'd0;
            hold_sel_q   <= 1'b0;
            from_rst_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            core0_q      <= core0_d;
            core1_q      <= core1_d;
            switching_q  <= switching_d;
            timeout_q    <= timeout_d;
            switch_cnt_q <= switch_cnt_d;
            hold_sel_q   <= hold_sel_d;
            from_rst_q   <= from_rst_d;
        end
    end

    assign bus.sel_o         = sel_q;
    assign bus.core0_rst_n_o = core0_q;
    assign bus.core1_rst_n_o = core1_q;
    assign bus.switching_o   = switching_q;
    assign bus.timeout_o     = timeout_q;
    assign bus.switch_cnt_o  = switch_cnt_q;

endmodule

// File: tb/tb_core_switch_ctrl.sv
// Bench for core_switch_ctrl: expected timing comes from the latency rule
// (sync + debounce + drain + hold), with a small model of sel/count/timeout.
module tb_core_switch_ctrl;

    localparam int SYNC     = 2;
    localparam int STABLE   = 16;
    localparam int DRAIN_TO = 255;
    localparam int HOLD     = 8;
    // Edge (counted from a select change) after which DRAIN is entered.
    localparam int ED       = SYNC + STABLE + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    core_switch_ctrl_if sif ();

    core_switch_ctrl #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .DRAIN_TIMEOUT(DRAIN_TO),
        .RST_HOLD     (HOLD),
        .CNT_W        (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic       m_sel;
    logic       m_timeout;
    logic [7:0] m_cnt;

    // Both cores must never run together.
    always @(negedge clk) begin
        n_tests++;
        if ((sif.core0_rst_n_o & sif.core1_rst_n_o) !== 1'b0) begin
            n_fail++;
            $display("FAIL both_run at %0t: core0=%b core1=%b, want never both 1",
                     $time, sif.core0_rst_n_o, sif.core1_rst_n_o);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Assert rst, check async values, release with chip_sel=cs and check the hold window.
    task automatic test_reset(input logic cs);
        logic [12:0] got, exp;
        @(negedge clk);
        sif.chip_sel_i = cs;
        sif.bus_req_i  = 1'b0;
        rst            = 1'b1;
        #1;
        got = {sif.sel_o, sif.core0_rst_n_o, sif.core1_rst_n_o, sif.switching_o,
               sif.timeout_o, sif.switch_cnt_o};
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_values: got %b want %b", got, exp);
        end
        @(negedge clk);
        rst       = 1'b0;
        m_sel     = cs;
        m_timeout = 1'b0;
        m_cnt     = 8'd0;
        for (int n = 1; n <= HOLD; n++) begin
            @(negedge clk);
            if (n < HOLD) begin
                got = {10'd0, sif.core0_rst_n_o, sif.core1_rst_n_o, sif.switching_o};
                exp = {10'd0, 1'b0, 1'b0, 1'b1};
            end else begin
                got = {sif.sel_o, sif.core0_rst_n_o, sif.core1_rst_n_o, sif.switching_o,
                       sif.timeout_o, sif.switch_cnt_o};
                exp = {cs, ~cs, cs, 1'b0, 1'b0, 8'd0};
            end
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_release cycle %0d: got %b want %b", n, got, exp);
            end
        end
    endtask

    // Short chip_sel pulse must be filtered: no switch, no reset, no switching flag.
    task automatic test_glitch(input int len);
        logic [3:0] got, exp;
        @(negedge clk);
        sif.chip_sel_i = ~m_sel;
        for (int n = 1; n <= len + 30; n++) begin
            @(negedge clk);
            if (n == len) sif.chip_sel_i = m_sel;
            got = {sif.sel_o, sif.core0_rst_n_o, sif.core1_rst_n_o, sif.switching_o};
            exp = {m_sel, ~m_sel, m_sel, 1'b0};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL glitch len %0d cycle %0d: got %b want %b", len, n, got, exp);
            end
        end
    endtask

    // One switch request to ~m_sel. bus_req stays high for the first d_req-1 drain
    // cycles; with revert the raw select goes back during DRAIN.
    task automatic run_switch(input int d_req, input bit revert, input string name);
        logic       old, tgt, fin;
        int         d, rel;
        logic [3:0] got, exp;
        logic [8:0] got_end, exp_end;
        old = m_sel;
        tgt = ~m_sel;
        fin = revert ? old : tgt;
        d   = (d_req > DRAIN_TO) ? DRAIN_TO : d_req;
        rel = ED + d + HOLD;
        @(negedge clk);
        sif.chip_sel_i = tgt;
        sif.bus_req_i  = (d_req > 1);
        for (int n = 1; n <= rel + 2; n++) begin
            @(negedge clk);
            if (revert && n == ED + 1) sif.chip_sel_i = old;
            if (n == ED + d_req - 1) sif.bus_req_i = 1'b0;
            exp[2] = (old == 1'b0 && n < ED + d) || (fin == 1'b0 && n >= rel);
            exp[1] = (old == 1'b1 && n < ED + d) || (fin == 1'b1 && n >= rel);
            exp[0] = (n >= ED && n < rel);
            if (n < ED + d || n >= rel) begin
                exp[3] = (n < ED + d) ? old : fin;
                got = {sif.sel_o, sif.core0_rst_n_o, sif.core1_rst_n_o, sif.switching_o};
            end else begin
                // sel_o is free to follow sync inside HOLD; not checked there.
                exp[3] = 1'b0;
                got = {1'b0, sif.core0_rst_n_o, sif.core1_rst_n_o, sif.switching_o};
            end
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d (drain %0d): got %b want %b",
                         name, n, d_req, got, exp);
            end
        end
        sif.bus_req_i = 1'b0;
        if (fin != old) m_cnt = m_cnt + 8'd1;
        m_timeout = m_timeout | (d_req > DRAIN_TO);
        m_sel     = fin;
        got_end = {sif.timeout_o, sif.switch_cnt_o};
        exp_end = {m_timeout, m_cnt};
        n_tests++;
        if (got_end !== exp_end) begin
            n_fail++;
            $display("FAIL %s end {timeout,switch_cnt}: got %b want %b", name, got_end, exp_end);
        end
    endtask

    task automatic test_clean_switch();
        run_switch(1, 1'b0, "clean_to0");
        run_switch(1, 1'b0, "clean_to1");
    endtask

    task automatic test_drain();
        run_switch(41, 1'b0, "drain40");
    endtask

    task automatic test_timeout();
        run_switch(300, 1'b0, "timeout");
        run_switch(2, 1'b0, "timeout_sticky");
    endtask

    task automatic test_revert();
        run_switch(5, 1'b1, "revert");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int dr;
            bit rv;
            dr = int'($urandom_range(1, 60));
            rv = (dr >= 2) && ($urandom_range(0, 1) == 1);
            run_switch(dr, rv, "random");
        end
    endtask

    // rst in the middle of HOLD must force reset values without waiting for a clock edge.
    task automatic test_abort();
        logic [12:0] got, exp;
        @(negedge clk);
        sif.chip_sel_i = ~m_sel;
        sif.bus_req_i  = 1'b0;
        repeat (ED + 4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        got = {sif.sel_o, sif.core0_rst_n_o, sif.core1_rst_n_o, sif.switching_o,
               sif.timeout_o, sif.switch_cnt_o};
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL abort_async: got %b want %b", got, exp);
        end
        test_reset(sif.chip_sel_i);
    endtask

    task automatic test_wrap();
        test_reset(1'b0);
        for (int i = 0; i < 256; i++) begin
            run_switch(int'($urandom_range(1, 3)), 1'b0, "wrap");
        end
        n_tests++;
        if (sif.switch_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: switch_cnt got %0d want 0", sif.switch_cnt_o);
        end
    endtask

    initial begin
        sif.chip_sel_i = 1'b0;
        sif.bus_req_i  = 1'b0;
        test_reset(1'b1);
        test_glitch(10);
        test_glitch(int'($urandom_range(1, 12)));
        test_clean_switch();
        test_drain();
        test_timeout();
        test_revert();
        test_random();
        test_glitch(int'($urandom_range(1, 12)));
        test_abort();
        test_clean_switch();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
